// File: rtl/dm_unit_pkg.sv
// Shared constants for the data-memory stage: access-type codes and helpers.
package dm_unit_pkg;

  typedef enum logic [2:0] {
    MemOp_w  = 3'd0,
    MemOp_h  = 3'd1,
    MemOp_hu = 3'd2,
    MemOp_b  = 3'd3,
    MemOp_bu = 3'd4
  } mem_op_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

endpackage

// File: rtl/dm_ext.sv
// Load lane select and extension: picks the byte/halfword out of a word and
// sign- or zero-extends it to 32 bits.
module dm_ext
  import dm_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  mem_op,
  output logic [31:0] result
);

  logic [15:0] hsel;
  logic [7:0]  bsel;

  always_comb begin
    hsel   = lane[1] ? word[31:16] : word[15:0];
    bsel   = word[{lane, 3'b000} +: 8];
    result = '0;
    case (mem_op_e'(mem_op))
      MemOp_w:  result = word;
      MemOp_h:  result = {{16{hsel[15]}}, hsel};
      MemOp_hu: result = {16'h0000, hsel};
      MemOp_b:  result = {{24{bsel[7]}}, bsel};
      MemOp_bu: result = {24'h000000, bsel};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/dm_unit.sv
// Data memory stage: byte-addressed word array with w/h/b loads and stores,
// alignment/range fault detection and a sticky first-fault record.
module dm_unit
  import dm_unit_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  mem_op,
  output logic [31:0] dout,
  output logic        addr_err,
  output logic        err_sticky,
  output logic [31:0] err_pc,
  output logic [31:0] err_addr
);

  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word;
  logic [31:0]       ext_out;
  logic [31:0]       lane_data;
  logic [31:0]       merged;
  logic [3:0]        be;
  logic              misaligned;
  logic              out_of_range;
  logic              we;

  assign idx     = addr[ADDR_W+1:2];
  assign rd_word = mem[idx];

  dm_ext u_ext (
    .word   (rd_word),
    .lane   (addr[1:0]),
    .mem_op (mem_op),
    .result (ext_out)
  );

  always_comb begin
    misaligned = 1'b0;
    case (mem_op_e'(mem_op))
      MemOp_w:           misaligned = (addr[1:0] != 2'b00);
      MemOp_h, MemOp_hu: misaligned = addr[0];
      default:           misaligned = 1'b0;
    endcase
  end

  assign out_of_range = |addr[31:ADDR_W+2];
  assign addr_err     = (mem_read | mem_write) &
                        (misaligned | out_of_range | ~op_legal(mem_op));
  assign dout         = addr_err ? '0 : ext_out;
  assign we           = mem_write & ~addr_err;

  // Store data is replicated across lanes so the byte-enable alone decides placement.
  always_comb begin
    be        = '0;
    lane_data = wdata;
    case (mem_op_e'(mem_op))
      MemOp_w: be = '1;
      MemOp_h, MemOp_hu: begin
        be        = addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
      end
      MemOp_b, MemOp_bu: begin
        be        = 4'b0001 << addr[1:0];
        lane_data = {4{wdata[7:0]}};
      end
      default: be = '0;
    endcase
    for (int unsigned i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? lane_data[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem[i[ADDR_W-1:0]] <= '0;
      end
    end else if (we) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sticky <= 1'b0;
      err_pc     <= '0;
      err_addr   <= '0;
    end else if (addr_err && !err_sticky) begin
      err_sticky <= 1'b1;
      err_pc     <= pc;
      err_addr   <= addr;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n && we) begin
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
    end
  end
`endif

endmodule

// File: tb/tb_dm_unit.sv
// Directed bench for dm_unit: behavioural memory model checked every cycle
// plus hand-computed expectations for the individual scenarios.
module tb_dm_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc, addr, wdata;
  logic        mem_write, mem_read;
  logic [2:0]  mem_op;
  logic [31:0] dout;
  logic        addr_err, err_sticky;
  logic [31:0] err_pc, err_addr;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  dm_unit #(.DEPTH_WORDS(1024), .ADDR_W(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc         (pc),
    .addr       (addr),
    .wdata      (wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_op     (mem_op),
    .dout       (dout),
    .addr_err   (addr_err),
    .err_sticky (err_sticky),
    .err_pc     (err_pc),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [1024];
  logic        m_sticky;
  logic [31:0] m_pc, m_addr;

  function automatic logic m_err(input logic [31:0] a, input logic [2:0] op,
                                 input logic rd, input logic wr);
    logic bad;
    bad = (op > 3'd4) || (a >= 32'd4096) ||
          (op == 3'd0 && a[1:0] != 2'b00) ||
          ((op == 3'd1 || op == 3'd2) && a[0]);
    return (rd || wr) && bad;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] a,
                                         input logic [2:0] op);
    logic [31:0] h, b;
    h = (w >> (a[1] ? 16 : 0)) & 32'h0000FFFF;
    b = (w >> (8 * a)) & 32'h000000FF;
    case (op)
      3'd0:    return w;
      3'd1:    return h[15] ? (h | 32'hFFFF0000) : h;
      3'd2:    return h;
      3'd3:    return b[7] ? (b | 32'hFFFFFF00) : b;
      3'd4:    return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [1:0] a,
                                          input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] mask, val;
    case (op)
      3'd1, 3'd2: begin
        mask = 32'h0000FFFF << (a[1] ? 16 : 0);
        val  = (wd & 32'h0000FFFF) << (a[1] ? 16 : 0);
      end
      3'd3, 3'd4: begin
        mask = 32'h000000FF << (8 * a);
        val  = (wd & 32'h000000FF) << (8 * a);
      end
      default: begin
        mask = 32'hFFFFFFFF;
        val  = wd;
      end
    endcase
    return (old & ~mask) | val;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 1024; i++) m_mem[i] <= 32'h0;
      m_sticky <= 1'b0;
      m_pc     <= 32'h0;
      m_addr   <= 32'h0;
    end else begin
      if (m_err(addr, mem_op, mem_read, mem_write) && !m_sticky) begin
        m_sticky <= 1'b1;
        m_pc     <= pc;
        m_addr   <= addr;
      end
      if (mem_write && !m_err(addr, mem_op, mem_read, mem_write))
        m_mem[addr[11:2]] <= m_store(m_mem[addr[11:2]], addr[1:0], mem_op, wdata);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m.addr_err", {31'b0, addr_err}, {31'b0, m_err(addr, mem_op, mem_read, mem_write)});
      if (m_err(addr, mem_op, mem_read, mem_write))
        check("m.dout", dout, 32'h0);
      else if (mem_op <= 3'd4)
        check("m.dout", dout, m_load(m_mem[addr[11:2]], addr[1:0], mem_op));
      check("m.err_sticky", {31'b0, err_sticky}, {31'b0, m_sticky});
      check("m.err_pc", err_pc, m_pc);
      check("m.err_addr", err_addr, m_addr);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d,
                       input logic wr, input logic rd, input logic [2:0] op);
    pc = p; addr = a; wdata = d; mem_write = wr; mem_read = rd; mem_op = op;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    pc = '0; addr = '0; wdata = '0; mem_write = 1'b0; mem_read = 1'b0; mem_op = 3'd0;
    #3;
    check("rst.dout", dout, 32'h0);
    check("rst.addr_err", {31'b0, addr_err}, 32'h0);
    check("rst.err_sticky", {31'b0, err_sticky}, 32'h0);
    check("rst.err_pc", err_pc, 32'h0);
    check("rst.err_addr", err_addr, 32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    drive(32'h3000, 32'h10, 32'h12345678, 1, 0, 3'd0);
    check("sw.old_dout", dout, 32'h0);
    tick();
    drive(32'h3004, 32'h10, 32'h0, 0, 1, 3'd0);
    check("lw10", dout, 32'h12345678);
    tick();

    drive(32'h3008, 32'h13, 32'h123456AB, 1, 0, 3'd3);
    tick();
    drive(32'h300C, 32'h10, 32'h0, 0, 1, 3'd0);
    check("sb.word", dout, 32'hAB345678);
    tick();
    drive(32'h3010, 32'h13, 32'h0, 0, 1, 3'd3);
    check("lb13", dout, 32'hFFFFFFAB);
    tick();
    drive(32'h3014, 32'h13, 32'h0, 0, 1, 3'd4);
    check("lbu13", dout, 32'h000000AB);
    tick();

    drive(32'h3018, 32'h20, 32'hCAFE1234, 1, 0, 3'd0);
    tick();
    drive(32'h301C, 32'h22, 32'h77778001, 1, 0, 3'd1);
    tick();
    drive(32'h3020, 32'h22, 32'h0, 0, 1, 3'd1);
    check("lh22", dout, 32'hFFFF8001);
    tick();
    drive(32'h3024, 32'h22, 32'h0, 0, 1, 3'd2);
    check("lhu22", dout, 32'h00008001);
    tick();
    drive(32'h3028, 32'h20, 32'h0, 0, 1, 3'd2);
    check("lhu20", dout, 32'h00001234);
    tick();
    drive(32'h302C, 32'h23, 32'h0, 0, 1, 3'd3);
    check("lb23", dout, 32'hFFFFFF80);
    tick();
    drive(32'h3030, 32'h21, 32'h0, 0, 1, 3'd3);
    check("lb21", dout, 32'h00000012);
    tick();

    drive(32'h3004, 32'h06, 32'hFFFFFFFF, 1, 0, 3'd0);
    check("mis.addr_err", {31'b0, addr_err}, 32'h1);
    check("mis.dout", dout, 32'h0);
    tick();
    drive(32'h3034, 32'h04, 32'h0, 0, 1, 3'd0);
    check("mis.sticky", {31'b0, err_sticky}, 32'h1);
    check("mis.err_pc", err_pc, 32'h3004);
    check("mis.err_addr", err_addr, 32'h6);
    check("mis.unchanged", dout, 32'h0);
    tick();

    drive(32'h3038, 32'h1000, 32'h0, 0, 1, 3'd0);
    check("oor.addr_err", {31'b0, addr_err}, 32'h1);
    check("oor.dout", dout, 32'h0);
    tick();
    drive(32'h303C, 32'h1000, 32'h0, 0, 0, 3'd0);
    check("oor.idle_err", {31'b0, addr_err}, 32'h0);
    check("oor.keep_addr", err_addr, 32'h6);
    check("oor.keep_pc", err_pc, 32'h3004);
    tick();

    drive(32'h3040, 32'h10, 32'h0, 0, 1, 3'd5);
    check("illegal.addr_err", {31'b0, addr_err}, 32'h1);
    tick();
    drive(32'h3044, 32'h21, 32'h0, 0, 1, 3'd2);
    check("lhu_odd.addr_err", {31'b0, addr_err}, 32'h1);
    tick();

    drive(32'h3048, 32'h10, 32'h00000055, 1, 0, 3'd0);
    reset_n = 1'b0;
    #1;
    check("mid.dout", dout, 32'h0);
    check("mid.err_sticky", {31'b0, err_sticky}, 32'h0);
    check("mid.err_pc", err_pc, 32'h0);
    check("mid.err_addr", err_addr, 32'h0);
    mem_write = 1'b0;
    reset_n   = 1'b1;
    tick();
    drive(32'h304C, 32'h10, 32'h0, 0, 1, 3'd0);
    check("mid.lw10", dout, 32'h0);
    tick();
    drive(32'h3050, 32'h20, 32'h0, 0, 1, 3'd0);
    check("mid.lw20", dout, 32'h0);
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
